reduce100_rx: RTL and testbench
===============================

REDUCE100_RX -- requirements
Module: reduce100_rx

Interface
REQ-001 SHALL have parameter NBITS, default 100, giving the number of data bits per frame (legal range 2..127).
REQ-002 SHALL have parameter ERR_W, default 8, giving the width of the parity-error counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_bit carries a serial bit this cycle.
REQ-006 SHALL have port in_bit, input, 1 bit: serial frame bit, data bit 0 first, then one parity bit.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts in_bit this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: a frame result is pending.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the pending result.
REQ-010 SHALL have port out_and, output, 1 bit: AND of all NBITS data bits of the last frame.
REQ-011 SHALL have port out_or, output, 1 bit: OR of all NBITS data bits of the last frame.
REQ-012 SHALL have port out_xor, output, 1 bit: XOR of all NBITS data bits of the last frame.
REQ-013 SHALL have port parity_err, output, 1 bit: received parity bit differs from out_xor (even parity).
REQ-014 SHALL have port err_count, output, ERR_W bits: saturating count of frames with parity_err set.
REQ-015 SHALL have port busy, output, 1 bit: a frame is partially received (state other than IDLE and HOLD).

Function
REQ-016 SHALL transfer a bit only in a cycle where in_valid and in_ready are both 1; with in_valid at 0, state and counter SHALL hold.
REQ-017 SHALL implement FSM IDLE, DATA, PARITY, HOLD, with in_ready 1 in IDLE, DATA and PARITY, and 0 in HOLD.
REQ-018 IDLE: a transfer SHALL load acc_and, acc_or and acc_xor with in_bit, set the counter to 1, and go to DATA.
REQ-019 DATA: a transfer SHALL apply acc_and&=bit, acc_or|=bit and acc_xor^=bit, and increment the counter.
REQ-019a DATA: when the transfer is data bit NBITS-1 (counter == NBITS-1), the FSM SHALL go to PARITY.
REQ-020 PARITY: a transfer SHALL register out_and, out_or and out_xor from the accumulators, register parity_err = in_bit ^ acc_xor, and go to HOLD.
REQ-021 out_valid SHALL be 1 exactly while in HOLD, i.e. from the cycle after parity-bit acceptance (latency 1) until handshake.
REQ-022 HOLD: out_valid && out_ready SHALL return the FSM to IDLE on that edge; in_valid during HOLD SHALL be ignored (one bubble cycle minimum between frames).
REQ-023 out_and, out_or, out_xor and parity_err SHALL stay stable from entry to HOLD until the next PARITY transfer, including after the handshake.
REQ-024 err_count SHALL increment on entry to HOLD when parity_err is set, and SHALL saturate at 2^ERR_W-1 without wrapping.
REQ-025 The counter width SHALL be $clog2(NBITS+1) and SHALL never exceed NBITS-1 in DATA.

Reset
REQ-026 areset SHALL asynchronously force state IDLE, counter 0, accumulators 0, and all outputs 0 except in_ready, which SHALL be 1.
REQ-027 areset asserted mid-frame or in HOLD SHALL discard the partial or pending result; the next accepted bit after release SHALL start a new frame.

Structure
REQ-028 Package reduce_pkg SHALL hold the FSM state enum, the NBITS_DEFAULT=100 constant and the counter-width function.
REQ-029 The accumulator triple (and/or/xor, with load and update controls) SHALL be the sub-module reduce_acc; the FSM, counter and output registers SHALL live in reduce100_rx.

Verification
REQ-030 100 zero data bits, parity 0, out_ready=1 -> out_and=0, out_or=0, out_xor=0, parity_err=0, err_count=0, out_valid high for 1 cycle.
REQ-031 100 one data bits, parity 0 -> out_and=1, out_or=1, out_xor=0, parity_err=0.
REQ-032 Only data bit 7 set, parity 0 -> out_and=0, out_or=1, out_xor=1, parity_err=1, err_count=1.
REQ-033 Random frame with in_valid low for 3 cycles every 10 bits -> results match the full-word reduction; busy=1 throughout the frame.
REQ-034 out_ready held 0 for 5 cycles in HOLD while in_valid=1 -> out_valid stays 1 and in_ready 0; the ignored bits are not counted; the next frame is correct.
REQ-035 areset at data bit 50, then a clean all-ones frame -> out_and=1; and 300 error frames -> err_count=255 (ERR_W=8).

Source files
------------

// File: rtl/reduce_pkg.sv
// Shared definitions for the reduce100_rx serial reduction receiver.
// Holds the receive FSM state encoding, the default frame length and the
// helper that sizes the bit counter so it can hold every value 0..NBITS.
package reduce_pkg;

   localparam int NBITS_DEFAULT = 100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      HOLD   = 2'd3
   } state_t;

   // Bit counter width: wide enough to hold NBITS itself.
   function automatic int cntWidth(input int nbits);
      return $clog2(nbits + 1);
   endfunction

endpackage

// File: rtl/reduce100_rx_if.sv
// Bus bundle for reduce100_rx.
// Input side : in_valid/in_bit from the producer, in_ready back to it.
// Output side: out_valid with out_and/out_or/out_xor/parity_err to the
//              consumer, out_ready back from it; err_count and busy are status.
// The slave modport is the receiver's view, master is the environment's.
interface reduce100_rx_if #(
   parameter int ERR_W = 8
);

   logic             in_valid;
   logic             in_bit;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic             out_and;
   logic             out_or;
   logic             out_xor;
   logic             parity_err;
   logic [ERR_W-1:0] err_count;
   logic             busy;

   modport slave (
      input  in_valid, in_bit, out_ready,
      output in_ready, out_valid, out_and, out_or, out_xor,
             parity_err, err_count, busy
   );

   modport master (
      output in_valid, in_bit, out_ready,
      input  in_ready, out_valid, out_and, out_or, out_xor,
             parity_err, err_count, busy
   );

endinterface

// File: rtl/reduce_acc.sv
// Running AND/OR/XOR accumulator for one serial frame.
// Ports: clk, areset (async, active-high), load_i (start a new frame with
// bit_i), update_i (fold bit_i into the running values), bit_i, and the
// three running reductions and_o, or_o, xor_o.
module reduce_acc (
   input  logic clk,
   input  logic areset,
   input  logic load_i,
   input  logic update_i,
   input  logic bit_i,
   output logic and_o,
   output logic or_o,
   output logic xor_o
);

   logic and_q, or_q, xor_q;

   // The first bit of a frame seeds all three reductions directly; later
   // bits are folded in. Load wins so a new frame never inherits old state.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         and_q <= 1'b0;
         or_q  <= 1'b0;
         xor_q <= 1'b0;
      end else if (load_i) begin
         and_q <= bit_i;
         or_q  <= bit_i;
         xor_q <= bit_i;
      end else if (update_i) begin
         and_q <= and_q & bit_i;
         or_q  <= or_q  | bit_i;
         xor_q <= xor_q ^ bit_i;
      end
   end

   assign and_o = and_q;
   assign or_o  = or_q;
   assign xor_o = xor_q;

endmodule

// File: rtl/reduce100_rx.sv
// Serial frame receiver: takes NBITS data bits (bit 0 first) followed by
// one even-parity bit, and presents the AND/OR/XOR of the data bits plus a
// parity error flag through a valid/ready output handshake.
// Ports: clk, areset (async, active-high), bus (reduce100_rx_if.slave)
// carrying the input handshake, result handshake, err_count and busy.
module reduce100_rx
   import reduce_pkg::*;
#(
   parameter int NBITS = NBITS_DEFAULT,
   parameter int ERR_W = 8
) (
   input  logic              clk,
   input  logic              areset,
   reduce100_rx_if.slave     bus
);

   localparam int             CW      = cntWidth(NBITS);
   localparam logic [CW-1:0]  LAST    = CW'(NBITS - 1);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic             inReady;
   logic             xfer;
   logic             accLoad, accUpdate, capture;
   logic             accAnd, accOr, accXor;
   logic             parityBad;
   logic             outAnd_q, outOr_q, outXor_q, parityErr_q;
   logic [ERR_W-1:0] errCount_q;

   assign inReady   = (state_q != HOLD);
   assign xfer      = bus.in_valid && inReady;
   assign parityBad = bus.in_bit ^ accXor;

   reduce_acc u_acc (
      .clk      (clk),
      .areset   (areset),
      .load_i   (accLoad),
      .update_i (accUpdate),
      .bit_i    (bus.in_bit),
      .and_o    (accAnd),
      .or_o     (accOr),
      .xor_o    (accXor)
   );

   // State and bit counter registers.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next-state logic. Every step only advances on an accepted bit, so an
   // idle input simply freezes the frame in place. HOLD ignores the input
   // entirely and waits for the consumer to take the result.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      accLoad   = 1'b0;
      accUpdate = 1'b0;
      capture   = 1'b0;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               accLoad = 1'b1;
               count_d = CW'(1);
               state_d = DATA;
            end
         end
         DATA: begin
            if (xfer) begin
               accUpdate = 1'b1;
               count_d   = count_q + 1'b1;
               if (count_q == LAST) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (xfer) begin
               capture = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Result registers only change when a parity bit is accepted, so the
   // last result stays visible after the handshake until the next frame
   // completes. The error counter sticks at its maximum instead of wrapping.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         outAnd_q    <= 1'b0;
         outOr_q     <= 1'b0;
         outXor_q    <= 1'b0;
         parityErr_q <= 1'b0;
         errCount_q  <= '0;
      end else if (capture) begin
         outAnd_q    <= accAnd;
         outOr_q     <= accOr;
         outXor_q    <= accXor;
         parityErr_q <= parityBad;
         if (parityBad && (errCount_q != ERR_MAX)) begin
            errCount_q <= errCount_q + 1'b1;
         end
      end
   end

   assign bus.in_ready   = inReady;
   assign bus.out_valid  = (state_q == HOLD);
   assign bus.busy       = (state_q == DATA) || (state_q == PARITY);
   assign bus.out_and    = outAnd_q;
   assign bus.out_or     = outOr_q;
   assign bus.out_xor    = outXor_q;
   assign bus.parity_err = parityErr_q;
   assign bus.err_count  = errCount_q;

endmodule

// File: tb/tb_reduce100_rx.sv
// Directed self-checking bench for reduce100_rx with the default 100-bit
// frame and 8-bit error counter. Inputs change on the falling clock edge
// and outputs are sampled there too, away from the active rising edge.
module tb_reduce100_rx;

   localparam int NB = 100;

   logic clk = 1'b0;
   logic areset;

   always #5 clk = ~clk;

   reduce100_rx_if #(.ERR_W(8)) bus ();

   reduce100_rx #(.NBITS(NB), .ERR_W(8)) dut (
      .clk    (clk),
      .areset (areset),
      .bus    (bus)
   );

   int         vectorCount = 0;
   int         missCount   = 0;
   logic [7:0] expErr      = '0;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Feed one frame: NB data bits then the parity bit. Optionally drop
   // in_valid for 3 cycles every 10 bits. Returns on the falling edge right
   // after the parity bit was taken, with in_valid low.
   task automatic applyStimulus(input logic [NB-1:0] data, input logic parity,
                                input bit gaps);
      bit readyOk = 1'b1;
      bit busyOk  = 1'b1;
      for (int i = 0; i < NB; i++) begin
         if (gaps && i != 0 && (i % 10) == 0) begin
            for (int g = 0; g < 3; g++) begin
               @(negedge clk);
               bus.in_valid = 1'b0;
               if (bus.busy !== 1'b1) busyOk = 1'b0;
            end
         end
         @(negedge clk);
         if (bus.in_ready !== 1'b1) readyOk = 1'b0;
         if (i > 0 && bus.busy !== 1'b1) busyOk = 1'b0;
         bus.in_valid = 1'b1;
         bus.in_bit   = data[i];
      end
      @(negedge clk);
      if (bus.in_ready !== 1'b1) readyOk = 1'b0;
      if (bus.busy !== 1'b1) busyOk = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_bit   = parity;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'b0;
      checkOutput("in_ready during frame", 32'(readyOk), 32'd1);
      checkOutput("busy during frame", 32'(busyOk), 32'd1);
   endtask

   // Check a presented result; if out_ready is high, also check that
   // out_valid drops after one cycle while the result stays put.
   task automatic checkResult(input string tag, input logic a, input logic o,
                              input logic x, input logic pe);
      if (pe && expErr != 8'hFF) expErr = expErr + 8'd1;
      checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({tag, " out_and"}, 32'(bus.out_and), 32'(a));
      checkOutput({tag, " out_or"}, 32'(bus.out_or), 32'(o));
      checkOutput({tag, " out_xor"}, 32'(bus.out_xor), 32'(x));
      checkOutput({tag, " parity_err"}, 32'(bus.parity_err), 32'(pe));
      checkOutput({tag, " err_count"}, 32'(bus.err_count), 32'(expErr));
      if (bus.out_ready) begin
         @(negedge clk);
         checkOutput({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
         checkOutput({tag, " out_xor held"}, 32'(bus.out_xor), 32'(x));
         checkOutput({tag, " out_and held"}, 32'(bus.out_and), 32'(a));
      end
   endtask

   initial begin
      logic [NB-1:0]  data;
      logic [127:0]   rnd;

      areset        = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'b0;
      bus.out_ready = 1'b1;
      #12;
      checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset err_count", 32'(bus.err_count), 32'd0);
      checkOutput("reset results", {28'd0, bus.out_and, bus.out_or,
                  bus.out_xor, bus.parity_err}, 32'd0);
      @(negedge clk);
      areset = 1'b0;

      // All zeros, correct parity.
      applyStimulus('0, 1'b0, 1'b0);
      checkResult("zeros", 1'b0, 1'b0, 1'b0, 1'b0);

      // All ones: 100 ones XOR to 0, so parity 0 is correct.
      applyStimulus('1, 1'b0, 1'b0);
      checkResult("ones", 1'b1, 1'b1, 1'b0, 1'b0);

      // Only bit 7 set, parity 0 is wrong.
      data = '0;
      data[7] = 1'b1;
      applyStimulus(data, 1'b0, 1'b0);
      checkResult("bit7", 1'b0, 1'b1, 1'b1, 1'b1);

      // Only the last data bit set, parity 1 is correct.
      data = '0;
      data[NB-1] = 1'b1;
      applyStimulus(data, 1'b1, 1'b0);
      checkResult("bit99", 1'b0, 1'b1, 1'b1, 1'b0);

      // All ones except bit 0, with stalls; parity matches.
      data = '1;
      data[0] = 1'b0;
      applyStimulus(data, 1'b1, 1'b1);
      checkResult("notbit0 gaps", 1'b0, 1'b1, 1'b1, 1'b0);

      // Random frame with stalls, correct parity.
      rnd  = {$urandom, $urandom, $urandom, $urandom};
      data = rnd[NB-1:0];
      applyStimulus(data, ^data, 1'b1);
      checkResult("random gaps", &data, |data, ^data, 1'b0);

      // Consumer stalls 5 cycles while the producer keeps pushing ones.
      bus.out_ready = 1'b0;
      data = '0;
      data[3] = 1'b1;
      data[60] = 1'b1;
      applyStimulus(data, 1'b1, 1'b0);
      checkResult("stall", 1'b0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         checkOutput("stall out_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("stall in_ready", 32'(bus.in_ready), 32'd0);
         bus.in_valid = 1'b1;
         bus.in_bit   = 1'b1;
         @(negedge clk);
      end
      checkOutput("stall out_valid end", 32'(bus.out_valid), 32'd1);
      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      checkOutput("stall released", 32'(bus.out_valid), 32'd0);
      checkOutput("stall in_ready back", 32'(bus.in_ready), 32'd1);
      data = '0;
      data[0] = 1'b1;
      applyStimulus(data, 1'b1, 1'b0);
      checkResult("after stall", 1'b0, 1'b1, 1'b1, 1'b0);

      // Reset at data bit 50 of a zeros frame, then a clean all-ones frame.
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_bit   = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("midframe busy", 32'(bus.busy), 32'd1);
      areset = 1'b1;
      #1;
      checkOutput("async reset busy", 32'(bus.busy), 32'd0);
      checkOutput("async reset err_count", 32'(bus.err_count), 32'd0);
      checkOutput("async reset out_or", 32'(bus.out_or), 32'd0);
      expErr = '0;
      @(negedge clk);
      areset = 1'b0;
      applyStimulus('1, 1'b0, 1'b0);
      checkResult("ones after reset", 1'b1, 1'b1, 1'b0, 1'b0);

      // 300 frames with bad parity: counter must stop at 255.
      for (int f = 0; f < 300; f++) begin
         applyStimulus('0, 1'b1, 1'b0);
         if (expErr != 8'hFF) expErr = expErr + 8'd1;
         if (f == 253) begin
            checkOutput("err_count 254", 32'(bus.err_count), 32'd254);
         end
      end
      checkOutput("err_count saturated", 32'(bus.err_count), 32'd255);
      checkOutput("err frame parity_err", 32'(bus.parity_err), 32'd1);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

   // Hard time limit so a stuck design still ends the run.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: got no finish, expected finish before limit");
      missCount++;
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $fatal(1, "[TB] time limit reached");
   end

endmodule
